// File: rtl/keypad_matrix_scanner.sv
// 4x3 keypad scanner: strobes rows one-hot, samples columns once per row period,
// debounces whole-frame results and reports one event per accepted press.
module keypad_matrix_scanner #(
    parameter int SCAN_DIV        = 1000000,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic       clk,
    input  logic       init,
    output logic [3:0] row,
    input  logic [2:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       multi_key
);

    localparam int              DIV_W     = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]      DEB_MAX   = 4'(DEBOUNCE_FRAMES);
    localparam logic [3:0]      CODE_NONE = 4'hF;

    typedef enum logic [1:0] {CAND_NONE, CAND_KEY, CAND_MULTI} cand_t;
    typedef enum logic [1:0] {ST_IDLE, ST_PRESSED, ST_MULTI} state_t;

    logic [DIV_W-1:0] div_reg;
    logic [1:0]       row_idx_reg;
    logic [3:0]       row_reg;
    logic [1:0]       acc_hits_reg;
    logic [3:0]       acc_code_reg;
    cand_t            prev_cand_reg;
    logic [3:0]       prev_code_reg;
    logic [3:0]       stable_reg;
    state_t           state_reg;
    logic [3:0]       key_code_reg;
    logic             key_valid_reg;
    logic             key_held_reg;
    logic             multi_key_reg;

    // Code of the lowest-numbered active column for each row.
    logic [3:0] row_code_lut [4];
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_row_map
            if (gi < 3) begin : g_digit
                assign row_code_lut[gi] = col[0] ? 4'(3 * gi + 1) :
                                          col[1] ? 4'(3 * gi + 2) : 4'(3 * gi + 3);
            end else begin : g_symbol
                assign row_code_lut[gi] = col[0] ? 4'd10 : col[1] ? 4'd0 : 4'd11;
            end
        end
    endgenerate

    logic       term;
    logic       frame_end;
    logic       row_multi;
    logic [1:0] row_hits;
    logic [2:0] hit_sum;
    logic [1:0] tot_hits;
    logic [3:0] frame_code;
    cand_t      cand_kind;
    logic [3:0] cand_code;
    logic [3:0] stable_next;

    always_comb begin
        term       = (div_reg == DIV_LAST);
        frame_end  = term && (row_idx_reg == 2'd3);
        row_multi  = (col[0] & col[1]) | (col[0] & col[2]) | (col[1] & col[2]);
        row_hits   = row_multi ? 2'd2 : ((|col) ? 2'd1 : 2'd0);
        hit_sum    = {1'b0, acc_hits_reg} + {1'b0, row_hits};
        tot_hits   = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        frame_code = (acc_hits_reg == 2'd0) ? row_code_lut[row_idx_reg] : acc_code_reg;
        cand_kind  = (tot_hits == 2'd0) ? CAND_NONE :
                     (tot_hits == 2'd1) ? CAND_KEY  : CAND_MULTI;
        cand_code  = (cand_kind == CAND_KEY) ? frame_code : CODE_NONE;
        if (cand_kind == prev_cand_reg && cand_code == prev_code_reg) begin
            stable_next = (stable_reg == DEB_MAX) ? DEB_MAX : stable_reg + 4'd1;
        end else begin
            stable_next = 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (init) begin
            div_reg       <= '0;
            row_idx_reg   <= 2'd0;
            row_reg       <= 4'b0001;
            acc_hits_reg  <= 2'd0;
            acc_code_reg  <= CODE_NONE;
            prev_cand_reg <= CAND_NONE;
            prev_code_reg <= CODE_NONE;
            stable_reg    <= 4'd0;
            state_reg     <= ST_IDLE;
            key_code_reg  <= CODE_NONE;
            key_valid_reg <= 1'b0;
            key_held_reg  <= 1'b0;
            multi_key_reg <= 1'b0;
        end else begin
            key_valid_reg <= 1'b0;
            if (term) begin
                div_reg     <= '0;
                row_idx_reg <= row_idx_reg + 2'd1;
                row_reg     <= {row_reg[2:0], row_reg[3]};
            end else begin
                div_reg <= div_reg + 1'b1;
            end

            if (frame_end) begin
                acc_hits_reg  <= 2'd0;
                acc_code_reg  <= CODE_NONE;
                prev_cand_reg <= cand_kind;
                prev_code_reg <= cand_code;
                stable_reg    <= stable_next;
                // Decisions use this frame's stability so the event lands one cycle after frame end.
                if (stable_next == DEB_MAX) begin
                    case (state_reg)
                        ST_IDLE: begin
                            if (cand_kind == CAND_KEY) begin
                                state_reg     <= ST_PRESSED;
                                key_code_reg  <= cand_code;
                                key_held_reg  <= 1'b1;
                                key_valid_reg <= 1'b1;
                            end else if (cand_kind == CAND_MULTI) begin
                                state_reg     <= ST_MULTI;
                                multi_key_reg <= 1'b1;
                            end
                        end
                        ST_PRESSED: begin
                            if (cand_kind == CAND_NONE) begin
                                state_reg    <= ST_IDLE;
                                key_held_reg <= 1'b0;
                                key_code_reg <= CODE_NONE;
                            end else if (cand_kind == CAND_MULTI) begin
                                state_reg     <= ST_MULTI;
                                key_held_reg  <= 1'b0;
                                key_code_reg  <= CODE_NONE;
                                multi_key_reg <= 1'b1;
                            end
                        end
                        ST_MULTI: begin
                            if (cand_kind == CAND_NONE) begin
                                state_reg     <= ST_IDLE;
                                multi_key_reg <= 1'b0;
                            end
                        end
                        default: state_reg <= ST_IDLE;
                    endcase
                end
            end else if (term) begin
                acc_hits_reg <= tot_hits;
                acc_code_reg <= frame_code;
            end
        end
    end

    assign row       = row_reg;
    assign key_code  = key_code_reg;
    assign key_valid = key_valid_reg;
    assign key_held  = key_held_reg;
    assign multi_key = multi_key_reg;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner: a key-matrix model drives col from row,
// expected key events go through a queue checked by a separate monitor.
module tb_keypad_matrix_scanner;

    localparam int SD = 4;
    localparam int DF = 2;

    logic       clk = 1'b0;
    logic       init = 1'b1;
    logic [3:0] row;
    logic [2:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       multi_key;

    logic [11:0] keys = '0;
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    logic last_valid = 1'b0;

    typedef struct {
        logic [3:0] code;
        int         at;
    } ev_t;
    ev_t exp_q[$];

    keypad_matrix_scanner #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
        .clk(clk), .init(init), .row(row), .col(col),
        .key_code(key_code), .key_valid(key_valid),
        .key_held(key_held), .multi_key(multi_key)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (init) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // Pressed keys close the switch between their row and column.
    always_comb begin
        col = '0;
        for (int r = 0; r < 4; r++) begin
            if (row[r]) col = col | keys[r*3 +: 3];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h cyc=%0d", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!init && key_valid) begin
            check("valid_not_consecutive", last_valid, 0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid got=1 want=0 code=%0d cyc=%0d", key_code, cyc);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                $display("event code=%0d cyc=%0d (expected code=%0d cyc=%0d)", key_code, cyc, e.code, e.at);
                check("event_code", key_code, e.code);
                check("event_cycle", cyc, e.at);
                check("event_held", key_held, 1);
            end
        end
        last_valid = key_valid;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int r, input int c);
        keys = '0;
        keys[r*3 + c] = 1'b1;
    endtask

    initial begin
        int s;
        logic [3:0] special_code [3];
        special_code[0] = 4'd10;
        special_code[1] = 4'd0;
        special_code[2] = 4'd11;

        repeat (2) @(posedge clk);
        #1 init = 1'b0;
        check("rst_row", row, 4'b0001);
        check("rst_code", key_code, 4'hF);
        check("rst_valid", key_valid, 0);
        check("rst_held", key_held, 0);
        check("rst_multi", multi_key, 0);
        tick(3);  check("row_c3", row, 4'b0001);
        tick(1);  check("row_c4", row, 4'b0010);
        tick(11); check("row_c15", row, 4'b1000);
        tick(1);  check("row_c16", row, 4'b0001);

        // key 5 held five frames, then released
        press(1, 1);
        s = cyc;
        exp_q.push_back('{code: 4'd5, at: s + 32});
        tick(31); check("k5_held_early", key_held, 0);
        tick(2);  check("k5_held", key_held, 1);
        check("k5_code", key_code, 4'd5);
        tick(47);
        keys = '0;
        tick(31); check("k5_held_release_early", key_held, 1);
        tick(1);  check("k5_released", key_held, 0);
        check("k5_code_none", key_code, 4'hF);

        // key 9 for a single frame only
        press(2, 2);
        tick(16);
        keys = '0;
        tick(48);
        check("bounce_held", key_held, 0);
        check("bounce_code", key_code, 4'hF);

        // keys 1 and 3 together, then key 1 alone, then release
        keys = '0;
        keys[0] = 1'b1;
        keys[2] = 1'b1;
        tick(31); check("multi_early", multi_key, 0);
        tick(1);  check("multi_set", multi_key, 1);
        tick(16);
        press(0, 0);
        tick(32);
        check("multi_single_multi", multi_key, 1);
        check("multi_single_held", key_held, 0);
        check("multi_single_code", key_code, 4'hF);
        keys = '0;
        tick(31); check("multi_release_early", multi_key, 1);
        tick(1);  check("multi_cleared", multi_key, 0);

        // *, 0 and # on row 3
        for (int i = 0; i < 3; i++) begin
            press(3, i);
            s = cyc;
            exp_q.push_back('{code: special_code[i], at: s + 32});
            tick(48);
            check("special_code", key_code, special_code[i]);
            keys = '0;
            tick(32);
            check("special_released", key_held, 0);
        end

        // key 7 with a reset pulse partway into its second frame
        press(2, 0);
        tick(21);
        init = 1'b1;
        @(posedge clk);
        #1 init = 1'b0;
        check("midrst_code", key_code, 4'hF);
        exp_q.push_back('{code: 4'd7, at: 32});
        tick(31); check("midrst_held_early", key_held, 0);
        tick(2);  check("midrst_held", key_held, 1);
        check("midrst_code7", key_code, 4'd7);
        keys = '0;
        tick(48);
        check("midrst_released", key_held, 0);

        tick(2);
        check("events_all_seen", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
